// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one finished functional-unit result per cycle
// round-robin and drives a registered broadcast plus a broadcast counter.
module cdb_arbiter #(
   parameter int unsigned NUM_UNITS  = 5,
   parameter int unsigned TAG_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [TAG_WIDTH-1:0] NO_TAG = 8'h7F
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_UNITS-1:0]           req_valid,
   input  logic [NUM_UNITS*TAG_WIDTH-1:0] req_tag,
   input  logic [NUM_UNITS*DATA_WIDTH-1:0] req_data,
   output logic [NUM_UNITS-1:0]           req_ready,
   output logic                           cdb_valid,
   output logic [TAG_WIDTH-1:0]           cdb_tag,
   output logic [DATA_WIDTH-1:0]          cdb_data,
   output logic                           err_tag,
   output logic [31:0]                    bcast_cnt
);

   localparam int unsigned PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;
   logic                  cdb_valid_q, cdb_valid_d;
   logic [TAG_WIDTH-1:0]  cdb_tag_q,   cdb_tag_d;
   logic [DATA_WIDTH-1:0] cdb_data_q,  cdb_data_d;
   logic                  err_tag_q,   err_tag_d;
   logic [31:0]           bcast_cnt_q, bcast_cnt_d;

   logic [TAG_WIDTH-1:0]  tag_arr  [NUM_UNITS];
   logic [DATA_WIDTH-1:0] data_arr [NUM_UNITS];

   logic                  found;
   logic [PTR_W-1:0]      winner;
   logic                  grant;
   logic [TAG_WIDTH-1:0]  win_tag;
   logic [DATA_WIDTH-1:0] win_data;

   for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
      assign tag_arr[g]  = req_tag[g*TAG_WIDTH +: TAG_WIDTH];
      assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Rotating scan from rr_ptr; the modulo is an explicit subtract so
   // non-power-of-two unit counts wrap correctly.
   always_comb begin
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_UNITS)) begin
            sum = sum - (PTR_W+1)'(NUM_UNITS);
         end
         idx = sum[PTR_W-1:0];
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign grant    = found && !rst;
   assign win_tag  = tag_arr[winner];
   assign win_data = data_arr[winner];

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      err_tag_d   = err_tag_q;
      bcast_cnt_d = bcast_cnt_q;
      if (grant) begin
         rr_ptr_d = (winner == PTR_W'(NUM_UNITS-1)) ? '0 : winner + PTR_W'(1);
         if (win_tag == NO_TAG) begin
            err_tag_d = 1'b1;
         end else begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = win_tag;
            cdb_data_d  = win_data;
            bcast_cnt_d = bcast_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= NO_TAG;
         cdb_data_q  <= '0;
         err_tag_q   <= 1'b0;
         bcast_cnt_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         err_tag_q   <= err_tag_d;
         bcast_cnt_q <= bcast_cnt_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign err_tag   = err_tag_q;
   assign bcast_cnt = bcast_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-cycle comparison against a round-robin model
// plus directed literal checks of the key scenarios.
module tb_cdb_arbiter;

   localparam int N  = 5;
   localparam int TW = 8;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*TW-1:0] req_tag;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic            err_tag;
   logic [31:0]     bcast_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_UNITS(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .NO_TAG(8'h7F)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag),
      .req_data(req_data), .req_ready(req_ready), .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .err_tag(err_tag),
      .bcast_cnt(bcast_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model state: what the registered outputs must be after the latest edge.
   bit          m_known = 0;
   int          m_ptr;
   bit          m_valid;
   logic [7:0]  m_tag;
   logic [31:0] m_data;
   bit          m_err;
   logic [31:0] m_cnt;

   always @(negedge clk) begin
      int          w;
      logic [N-1:0] exp_ready;
      logic [7:0]  t;
      w = -1;
      exp_ready = '0;
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         end
         if (w >= 0) exp_ready[w] = 1'b1;
      end
      if (m_known) begin
         check("m_ready", 64'(req_ready), 64'(exp_ready));
         check("m_cdb_valid", 64'(cdb_valid), 64'(m_valid));
         check("m_cdb_tag", 64'(cdb_tag), 64'(m_tag));
         check("m_cdb_data", 64'(cdb_data), 64'(m_data));
         check("m_err_tag", 64'(err_tag), 64'(m_err));
         check("m_bcast_cnt", 64'(bcast_cnt), 64'(m_cnt));
      end
      if (rst) begin
         m_known = 1; m_ptr = 0; m_valid = 0; m_tag = 8'h7F;
         m_data = 0; m_err = 0; m_cnt = 0;
      end else if (m_known) begin
         m_valid = 0;
         if (w >= 0) begin
            t = req_tag[w*TW +: TW];
            m_ptr = (w + 1) % N;
            if (t == 8'h7F) m_err = 1;
            else begin
               m_valid = 1; m_tag = t; m_data = req_data[w*DW +: DW]; m_cnt = m_cnt + 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_unit(input int i, input logic [7:0] t, input logic [31:0] d);
      req_tag[i*TW +: TW] = t;
      req_data[i*DW +: DW] = d;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 5'b11111;
      for (int i = 0; i < N; i++) set_unit(i, 8'h10 + 8'(i), 32'd100 + 32'(i));
      #3 check("rst_ready0", 64'(req_ready), 64'd0);
      tick(); #2;
      check("rst_ready1", 64'(req_ready), 64'd0);
      check("rst_valid", 64'(cdb_valid), 64'd0);
      check("rst_tag", 64'(cdb_tag), 64'h7F);
      check("rst_cnt", 64'(bcast_cnt), 64'd0);
      tick(); rst = 1'b0; req_valid = '0;
      tick(); tick();

      // Single requester: unit 2, tag 03, data 42.
      req_valid = 5'b00100; set_unit(2, 8'h03, 32'd42);
      #2 check("single_ready", 64'(req_ready), 64'b00100);
      tick(); req_valid = '0; set_unit(2, 8'h12, 32'd102);
      #2;
      check("single_valid", 64'(cdb_valid), 64'd1);
      check("single_tag", 64'(cdb_tag), 64'h03);
      check("single_data", 64'(cdb_data), 64'd42);
      check("single_cnt", 64'(bcast_cnt), 64'd1);

      // Rotation skip: pointer now 3, units 1 and 4 valid.
      tick(); req_valid = 5'b10010;
      #2 check("skip_first", 64'(req_ready), 64'b10000);
      tick(); req_valid = 5'b00010;
      #2;
      check("skip_second", 64'(req_ready), 64'b00010);
      check("skip_tag4", 64'(cdb_tag), 64'h14);
      tick(); req_valid = 5'b11111;
      #2;
      check("skip_ptr2", 64'(req_ready), 64'b00100);
      check("skip_tag1", 64'(cdb_tag), 64'h11);
      tick(); req_valid = '0;

      // Reserved tag on unit 0; pointer now 3, scan 3,4,0.
      tick(); req_valid = 5'b00001; set_unit(0, 8'h7F, 32'hDEAD);
      #2 check("rsv_ready", 64'(req_ready), 64'b00001);
      tick(); req_valid = '0; set_unit(0, 8'h10, 32'd100);
      #2;
      check("rsv_valid", 64'(cdb_valid), 64'd0);
      check("rsv_err", 64'(err_tag), 64'd1);
      check("rsv_cnt", 64'(bcast_cnt), 64'd4);
      tick(); tick(); tick();
      #2 check("rsv_sticky", 64'(err_tag), 64'd1);

      // Reset in the cycle unit 3 would win (pointer is 1).
      tick(); rst = 1'b1; req_valid = 5'b01000;
      #2 check("mid_rst_ready", 64'(req_ready), 64'd0);
      tick(); rst = 1'b0;
      #2;
      check("mid_post_ready", 64'(req_ready), 64'b01000);
      check("mid_post_valid", 64'(cdb_valid), 64'd0);
      check("mid_post_err", 64'(err_tag), 64'd0);
      check("mid_post_cnt", 64'(bcast_cnt), 64'd0);
      tick(); req_valid = '0;
      #2;
      check("mid_bcast_tag", 64'(cdb_tag), 64'h13);
      check("mid_bcast_cnt", 64'(bcast_cnt), 64'd1);

      // Full contention from reset.
      tick(); rst = 1'b1;
      tick(); rst = 1'b0; req_valid = 5'b11111;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         #2 check("full_grant", 64'(req_ready), 64'(5'b00001 << (k % N)));
      end
      tick();
      #2;
      check("full_cnt10", 64'(bcast_cnt), 64'd10);
      check("full_valid", 64'(cdb_valid), 64'd1);
      check("full_last_tag", 64'(cdb_tag), 64'h14);
      tick(); req_valid = '0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
